// File: rtl/rptr_empty_lvl.sv
// Read-side pointer, empty, fill-level, almost-empty and underflow tracking for the async FIFO.
// Every register sits in the rclk domain; rq2_wptr arrives already synchronised.
module rptr_empty_lvl #(
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [ADDRSIZE:0]   rae_thresh,
  input  logic                rerr_clr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   rcount,
  output logic                runderflow
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] rcount_next;
  logic          rd_ok;
  logic          rempty_next;
  logic          ralmost_empty_next;
  logic          runderflow_next;

  // Next-state pointer, level and flag logic
  always_comb begin
    rd_ok              = 1'b0;
    rbinnext           = rbin;
    rgraynext          = '0;
    wbin_s             = '0;
    rcount_next        = '0;
    rempty_next        = 1'b1;
    ralmost_empty_next = 1'b1;
    runderflow_next    = runderflow;

    rd_ok     = rinc & ~rempty;
    rbinnext  = rbin + PW'(rd_ok);
    rgraynext = (rbinnext >> 1) ^ rbinnext;

    // Gray-to-binary as an XOR prefix from the MSB down
    wbin_s[PW-1] = rq2_wptr[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      wbin_s[i] = wbin_s[i+1] ^ rq2_wptr[i];
    end

    rcount_next        = wbin_s - rbinnext;
    rempty_next        = (rgraynext == rq2_wptr);
    ralmost_empty_next = (rcount_next <= rae_thresh);

    // A fresh underflow takes priority over a clear on the same edge
    if (rinc && rempty) begin
      runderflow_next = 1'b1;
    end else if (rerr_clr) begin
      runderflow_next = 1'b0;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rcount        <= '0;
      runderflow    <= 1'b0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= rempty_next;
      ralmost_empty <= ralmost_empty_next;
      rcount        <= rcount_next;
      runderflow    <= runderflow_next;
    end
  end

  assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed bench for rptr_empty_lvl (ADDRSIZE=4): reset, reads, empty, underflow, wrap, mid-run reset.
module tb_rptr_empty_lvl;

  localparam int unsigned ADDRSIZE = 4;

  logic                rclk = 1'b0;
  logic                rrst;
  logic                rinc;
  logic [ADDRSIZE:0]   rq2_wptr;
  logic [ADDRSIZE:0]   rae_thresh;
  logic                rerr_clr;
  logic                rempty;
  logic                ralmost_empty;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE:0]   rcount;
  logic                runderflow;

  int npass = 0;
  int ntot  = 0;

  rptr_empty_lvl #(.ADDRSIZE(ADDRSIZE)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .rae_thresh    (rae_thresh),
    .rerr_clr      (rerr_clr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .raddr         (raddr),
    .rptr          (rptr),
    .rcount        (rcount),
    .runderflow    (runderflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [ADDRSIZE:0] to_gray(input logic [ADDRSIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One rising edge, then settle past it before sampling/driving
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e, input logic ae,
                           input logic [3:0] a, input logic [4:0] p,
                           input logic [4:0] c, input logic u);
    check({tag, ".rempty"},        32'(rempty),        32'(e));
    check({tag, ".ralmost_empty"}, 32'(ralmost_empty), 32'(ae));
    check({tag, ".raddr"},         32'(raddr),         32'(a));
    check({tag, ".rptr"},          32'(rptr),          32'(p));
    check({tag, ".rcount"},        32'(rcount),        32'(c));
    check({tag, ".runderflow"},    32'(runderflow),    32'(u));
  endtask

  logic [ADDRSIZE:0] wb;

  initial begin
    rrst = 1'b1; rinc = 1'b0; rq2_wptr = '0; rae_thresh = 5'd2; rerr_clr = 1'b0;
    #1;
    tick(); tick();
    check_all("reset", 1'b1, 1'b1, 4'd0, 5'b00000, 5'd0, 1'b0);
    rrst = 1'b0;

    // Three entries written (Gray 3)
    rq2_wptr = 5'b00010;
    tick();
    check_all("fill3", 1'b0, 1'b0, 4'd0, 5'b00000, 5'd3, 1'b0);

    rinc = 1'b1;
    tick();
    check_all("rd1", 1'b0, 1'b1, 4'd1, 5'b00001, 5'd2, 1'b0);
    tick();
    check_all("rd2", 1'b0, 1'b1, 4'd2, 5'b00011, 5'd1, 1'b0);
    tick();
    check_all("rd3", 1'b1, 1'b1, 4'd3, 5'b00010, 5'd0, 1'b0);

    // Read while empty: dropped, sticky error set
    tick();
    check_all("uflow", 1'b1, 1'b1, 4'd3, 5'b00010, 5'd0, 1'b1);
    rinc = 1'b0; rerr_clr = 1'b1;
    tick();
    check("clr", 32'(runderflow), 32'd0);
    rinc = 1'b1; rerr_clr = 1'b1;
    tick();
    check("set_wins", 32'(runderflow), 32'd1);
    check("set_wins.rptr", 32'(rptr), 32'(5'b00010));
    rinc = 1'b0; rerr_clr = 1'b1;
    tick();
    check("clr2", 32'(runderflow), 32'd0);
    rerr_clr = 1'b0;

    // Single write/read pairs: 29 to reach rbin=0, then 32 more for a full wrap
    wb = 5'd3;
    for (int k = 0; k < 61; k++) begin
      wb = wb + 5'd1;
      rq2_wptr = to_gray(wb);
      rinc = 1'b0;
      tick();
      if (k == 0 || k == 28 || k == 60) begin
        check($sformatf("wr%0d.rempty", k), 32'(rempty), 32'd0);
        check($sformatf("wr%0d.rcount", k), 32'(rcount), 32'd1);
        check($sformatf("wr%0d.ae", k),     32'(ralmost_empty), 32'd1);
      end
      rinc = 1'b1;
      tick();
      check($sformatf("rdw%0d.rempty", k), 32'(rempty), 32'd1);
      if (k == 28) check_all("wrap0", 1'b1, 1'b1, 4'd0, 5'b00000, 5'd0, 1'b0);
    end
    rinc = 1'b0;
    check_all("wrap32", 1'b1, 1'b1, 4'd0, 5'b00000, 5'd0, 1'b0);

    // Completely full: Gray 16 with rbin=0
    rq2_wptr = 5'b11000;
    tick();
    check_all("full", 1'b0, 1'b0, 4'd0, 5'b00000, 5'd16, 1'b0);

    // rae_thresh=0 tracks rempty; level 16 still not almost empty
    rae_thresh = 5'd0;
    tick();
    check("thr0.ae", 32'(ralmost_empty), 32'd0);
    rae_thresh = 5'd16;
    tick();
    check("thr16.ae", 32'(ralmost_empty), 32'd1);
    rae_thresh = 5'd2;

    // Reset mid-run with a pending read
    rq2_wptr = 5'b00111;
    tick();
    check("lvl5.rcount", 32'(rcount), 32'd5);
    rinc = 1'b1; rrst = 1'b1;
    tick();
    check_all("rst_mid", 1'b1, 1'b1, 4'd0, 5'b00000, 5'd0, 1'b0);
    rinc = 1'b0; rrst = 1'b0;
    tick();
    check_all("post_rst", 1'b0, 1'b0, 4'd0, 5'b00000, 5'd5, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
